audio_playback_buffer: RTL and testbench
========================================

# audio_playback_buffer

Consumes the audio byte stream from `image_audio_splitter` (its `audio_axiov`/`audio` outputs) and plays it out as an 8-bit unsigned PWM signal at a fixed sample rate. Packet arrival over Ethernet is bursty, so the block buffers bytes in a FIFO. It primes to a threshold before playback starts, and it re-primes after an underflow. It sits beside `frame_packager` on the audio branch, and its PWM output drives the board audio pin.

## Interface
Parameters:
- DEPTH, 1024, FIFO depth in bytes; must be a power of 2.
- PRIME_LEVEL, 512, fill level required to start or restart playback; range 1..DEPTH.
- SAMPLE_PERIOD, 1134, clk cycles per audio sample (50 MHz / ~44.1 kHz); must be ≥ 256.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-high.
- audio_axiiv  in  1  input byte valid; no backpressure.
- audio_axiid  in  8  unsigned audio sample byte.
- sample_axiov  out  1  one-cycle pulse when a new sample is presented.
- sample_axiod  out  8  current sample (unsigned; 8'h80 = silence).
- pwm_out  out  1  PWM audio output.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- playing  out  1  high in PLAYING state.
- overflow  out  1  one-cycle pulse per dropped input byte.
- underflow  out  1  one-cycle pulse when a sample tick finds the FIFO empty while PLAYING.

## Operation
- **Reset values:**
  - FIFO pointers and fill = 0; state = PRIMING.
  - sample_axiov = 0, sample_axiod = 8'h80, duty = 8'h80.
  - pwm_out = 0, playing = 0, overflow = 0, underflow = 0.
  - Tick counter = 0, PWM counter = 0. FIFO contents are discarded.
- **Write:** on audio_axiiv, the byte is written at wr_ptr and wr_ptr increments modulo DEPTH. The write is accepted if fill < DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow pulses.
- **Tick counter:** free-running 0..SAMPLE_PERIOD-1, independent of state. A tick occurs in the cycle where the count equals SAMPLE_PERIOD-1.
- **State machine:**
  - PRIMING → PLAYING when fill ≥ PRIME_LEVEL, evaluated every cycle with the registered fill.
  - In PLAYING, each tick with fill > 0 pops one byte. The byte goes to sample_axiod and sample_axiov pulses.
  - PLAYING → PRIMING on a tick with fill = 0. underflow pulses, sample_axiod is set to 8'h80, and sample_axiov pulses.
  - In PRIMING, ticks produce no pop and no sample_axiov; sample_axiod holds its value.
- **Fill:** +1 on an accepted write, −1 on a pop, unchanged when both or neither occur.
- **Pointer arithmetic:** pointers are $clog2(DEPTH) bits and wrap naturally.
- **PWM:**
  - 8-bit free-running counter; pwm_out is registered and equals (pwm_cnt < duty).
  - duty loads from sample_axiod only when pwm_cnt = 255, so a PWM period never glitches mid-way.
  - duty 0 gives constant 0; duty 255 gives high for 255 of 256 cycles.
- **Async reset mid-operation:** everything returns to the reset values immediately. The next valid byte after rst deasserts is treated as the first byte.

## Timing
- Write to fill update: 1 cycle (fill reflects the write in the cycle after audio_axiiv).
- PRIMING → PLAYING: playing rises 1 cycle after fill reaches PRIME_LEVEL.
- Tick to sample: sample_axiod/sample_axiov are registered and valid in the cycle after the tick.
- Sample to duty: duty updates at the next pwm_cnt = 255, so a sample is audible within 256 cycles.
- overflow is asserted in the cycle after the dropped write. underflow is asserted in the cycle after the tick.
- Write throughput: one byte per cycle sustained; there is no stall path.

## Test plan
- **Reset:** assert rst at arbitrary times.
  - Required: fill = 0, playing = 0, sample_axiod = 8'h80, pwm_out = 0, no pulses.
  - Required: a reset asserted mid-playback clears fill within the same cycle (asynchronous).
- **Priming and order:** write bytes 0..511 back-to-back.
  - Required: playing rises 1 cycle after fill = 512.
  - Required: successive sample_axiov pulses, SAMPLE_PERIOD apart, deliver 0, 1, 2, … in order.
- **Overflow:** set SAMPLE_PERIOD = 4000 and write 1100 consecutive bytes starting at reset release.
  - Required: fill saturates at 1024.
  - Required: exactly 76 overflow pulses, and the retained data is bytes 0..1023.
- **Underflow:** prime with 512 bytes, then stop input.
  - Required: 512 samples are delivered.
  - Required: the 513th tick gives an underflow pulse, sample_axiod = 8'h80, and playing = 0.
  - Required: no further sample_axiov until fill reaches 512 again.
- **PWM:** hold constant sample values and count high cycles over one full PWM period.
  - Required: 8'h40 gives 64 high cycles per 256, 8'h00 gives 0, 8'hFF gives 255.
  - Required: duty changes only at the pwm_cnt wrap.
- **Simultaneous push and pop:** with fill = DEPTH, drive a write in the same cycle as a tick.
  - Required: the write is accepted, fill stays 1024, and there is no overflow pulse.

Source files
------------

// File: rtl/audio_playback_buffer.sv
// Purpose: buffers the bursty audio byte stream in a FIFO, primes to a threshold, then plays samples out as 8-bit PWM.
// Latency: fill follows a write by 1 cycle; a sample appears 1 cycle after its tick; duty follows within 256 cycles.
// Backpressure: none; a byte arriving while the FIFO is full (and no pop that cycle) is dropped and flagged on overflow.
//
// Ports:
//   clk, rst                  system clock, async active-high reset
//   audio_axiiv/audio_axiid   incoming byte valid / unsigned sample byte
//   sample_axiov/sample_axiod one-cycle new-sample pulse / current sample (8'h80 = silence)
//   pwm_out                   registered PWM output, high while pwm_cnt < duty
//   fill                      FIFO occupancy 0..DEPTH
//   playing                   high while in PLAYING
//   overflow/underflow        one-cycle event pulses (dropped byte / empty FIFO at a playing tick)
module audio_playback_buffer #(
    parameter int DEPTH         = 1024,
    parameter int PRIME_LEVEL   = 512,
    parameter int SAMPLE_PERIOD = 1134
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       audio_axiiv,
    input  logic [7:0]                 audio_axiid,
    output logic                       sample_axiov,
    output logic [7:0]                 sample_axiod,
    output logic                       pwm_out,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       playing,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int TW = $clog2(SAMPLE_PERIOD);

    localparam logic [FW-1:0] DEPTH_F   = FW'(DEPTH);
    localparam logic [FW-1:0] PRIME_F   = FW'(PRIME_LEVEL);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);

    typedef enum logic {
        PRIMING = 1'b0,
        PLAYING = 1'b1
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    pwm_cnt;
    logic [7:0]    duty;
    state_t        state;
    state_t        state_nxt;
    logic          tick;
    logic          pop;
    logic          underflow_evt;
    logic          wr_acc;

    // Sample-rate tick runs regardless of state so the output rate never drifts.
    assign tick    = (tick_cnt == TICK_LAST);
    assign playing = (state == PLAYING);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a byte then.
    assign wr_acc  = audio_axiiv && ((fill != DEPTH_F) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRIMING;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        underflow_evt = 1'b0;
        case (state)
            PRIMING: begin
                if (fill >= PRIME_F) begin
                    state_nxt = PLAYING;
                end
            end
            PLAYING: begin
                if (tick) begin
                    if (fill != '0) begin
                        pop = 1'b1;
                    end else begin
                        underflow_evt = 1'b1;
                        state_nxt     = PRIMING;
                    end
                end
            end
            default: state_nxt = PRIMING;
        endcase
    end

    // Storage carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= audio_axiid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            tick_cnt     <= '0;
            sample_axiov <= 1'b0;
            sample_axiod <= 8'h80;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            overflow  <= audio_axiiv && !wr_acc;
            underflow <= underflow_evt;

            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({wr_acc, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase

            // When full, wr_ptr == rd_ptr: the read here sees the old byte, not the one being written.
            if (pop) begin
                sample_axiod <= mem[rd_ptr];
                sample_axiov <= 1'b1;
            end else if (underflow_evt) begin
                sample_axiod <= 8'h80;
                sample_axiov <= 1'b1;
            end else begin
                sample_axiov <= 1'b0;
            end
        end
    end

    // Duty only reloads at the counter wrap so a PWM period is never split between two samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 8'h00;
            duty    <= 8'h80;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            pwm_out <= (pwm_cnt < duty);
            if (pwm_cnt == 8'hFF) begin
                duty <= sample_axiod;
            end
        end
    end

endmodule

// File: tb/tb_audio_playback_buffer.sv
// Purpose: self-checking bench for audio_playback_buffer on a small configuration (DEPTH 16, prime 8, period 300).
// Latency: expectations are indexed by cyc, the number of clock edges since reset release.
// Backpressure: the DUT has none; the bench drives bytes freely and counts dropped-byte pulses.
module tb_audio_playback_buffer;

    localparam int DEPTH  = 16;
    localparam int PRIME  = 8;
    localparam int PERIOD = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       audio_axiiv;
    logic [7:0] audio_axiid;
    logic       sample_axiov;
    logic [7:0] sample_axiod;
    logic       pwm_out;
    logic [4:0] fill;
    logic       playing;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int n_v  = 0;
    int n_ov = 0;
    int n_uf = 0;

    audio_playback_buffer #(
        .DEPTH         (DEPTH),
        .PRIME_LEVEL   (PRIME),
        .SAMPLE_PERIOD (PERIOD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .audio_axiiv  (audio_axiiv),
        .audio_axiid  (audio_axiid),
        .sample_axiov (sample_axiov),
        .sample_axiod (sample_axiod),
        .pwm_out      (pwm_out),
        .fill         (fill),
        .playing      (playing),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Edge count since reset release; after edge e, cyc == e at the following negedge.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_v  = n_v  + int'(sample_axiov);
            n_ov = n_ov + int'(overflow);
            n_uf = n_uf + int'(underflow);
        end
    end

    typedef struct {
        logic [7:0] val;
        int         exp_high;
    } pwm_vec_t;

    pwm_vec_t vec [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] first, input int n, input bit inc);
        for (int i = 0; i < n; i++) begin
            audio_axiiv = 1'b1;
            audio_axiid = inc ? first + 8'(i) : first;
            @(negedge clk);
        end
        audio_axiiv = 1'b0;
    endtask

    task automatic count_high(input int lo, input int hi, output int n);
        n = 0;
        for (int e = lo; e <= hi; e++) begin
            run_to(e);
            n += int'(pwm_out);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_v;
        int snap_ov;
        int snap_uf;
        int hi_cnt;

        vec[0] = '{8'h40, 64};
        vec[1] = '{8'h00, 0};
        vec[2] = '{8'hFF, 255};
        vec[3] = '{8'h80, 128};
        vec[4] = '{8'h01, 1};

        rst         = 1'b1;
        audio_axiiv = 1'b0;
        audio_axiid = 8'h00;
        @(negedge clk);
        chk("rst_pwm_during", int'(pwm_out), 0);
        do_reset();

        // Reset values
        chk("rst_fill",      int'(fill), 0);
        chk("rst_playing",   int'(playing), 0);
        chk("rst_sample",    int'(sample_axiod), 8'h80);
        chk("rst_axiov",     int'(sample_axiov), 0);
        chk("rst_pwm",       int'(pwm_out), 0);
        chk("rst_overflow",  int'(overflow), 0);
        chk("rst_underflow", int'(underflow), 0);

        // Priming and in-order playback
        wr(8'h00, PRIME, 1'b1);
        chk("prime_fill",         int'(fill), 8);
        chk("prime_playing_low",  int'(playing), 0);
        run_to(9);
        chk("prime_playing_high", int'(playing), 1);
        snap_v  = n_v;
        snap_uf = n_uf;
        for (int k = 1; k <= 8; k++) begin
            run_to(PERIOD * k);
            chk("order_axiov", int'(sample_axiov), 1);
            chk("order_value", int'(sample_axiod), k - 1);
        end
        run_to(2401);
        chk("order_pulse_count", n_v - snap_v, 8);
        run_to(2699);
        chk("drain_fill",    int'(fill), 0);
        chk("drain_playing", int'(playing), 1);
        run_to(2700);
        chk("uf_pulse",   int'(underflow), 1);
        chk("uf_axiov",   int'(sample_axiov), 1);
        chk("uf_sample",  int'(sample_axiod), 8'h80);
        chk("uf_playing", int'(playing), 0);
        run_to(2701);
        chk("uf_one_cycle",  int'(underflow), 0);
        chk("uf_pulse_count", n_uf - snap_uf, 1);
        snap_v = n_v;
        run_to(3300);
        chk("uf_silent", n_v - snap_v, 0);

        // Re-prime after underflow
        wr(8'h10, PRIME, 1'b1);
        run_to(3599);
        chk("reprime_playing", int'(playing), 1);
        run_to(3600);
        chk("reprime_axiov", int'(sample_axiov), 1);
        chk("reprime_value", int'(sample_axiod), 8'h10);

        // Asynchronous reset mid-playback
        run_to(3610);
        chk("mid_fill_before", int'(fill), 7);
        #2 rst = 1'b1;
        #1;
        chk("async_fill",    int'(fill), 0);
        chk("async_playing", int'(playing), 0);
        chk("async_sample",  int'(sample_axiod), 8'h80);
        chk("async_pwm",     int'(pwm_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Overflow, then simultaneous push and pop at full
        snap_ov = n_ov;
        wr(8'h00, 20, 1'b1);
        chk("ovf_fill_sat", int'(fill), DEPTH);
        run_to(21);
        chk("ovf_pulse_count", n_ov - snap_ov, 4);
        run_to(299);
        chk("pp_fill_before", int'(fill), DEPTH);
        wr(8'hAA, 1, 1'b0);
        chk("pp_fill_after", int'(fill), DEPTH);
        chk("pp_no_overflow", int'(overflow), 0);
        chk("pp_axiov", int'(sample_axiov), 1);
        chk("pp_value0", int'(sample_axiod), 0);
        for (int k = 2; k <= DEPTH + 1; k++) begin
            run_to(PERIOD * k);
            chk("ovf_retained", int'(sample_axiod), (k <= DEPTH) ? k - 1 : 8'hAA);
        end
        run_to(PERIOD * (DEPTH + 1) + 1);
        chk("ovf_pulse_total", n_ov - snap_ov, 4);

        // PWM duty: window [257,512] still uses the reset duty although the sample changes at edge 300
        for (int r = 0; r < 5; r++) begin
            do_reset();
            wr(vec[r].val, PRIME, 1'b0);
            count_high(257, 512, hi_cnt);
            chk("pwm_no_midperiod_change", hi_cnt, 128);
            count_high(513, 768, hi_cnt);
            chk("pwm_high_count", hi_cnt, vec[r].exp_high);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
